// File: rtl/tcp_rt_timer_table.sv
// Per-flow TCP retransmit timers with duplicate-ACK fast retransmit detection.
// A round-robin scanner ages one flow per cycle; a registered arbiter emits retransmit requests.

module tcp_rt_flow_entry #(
  parameter int TIMESTAMP_W       = 64,
  parameter int RT_TIMEOUT_CYCLES = 250000000,
  parameter int DUP_ACK_CNT_W     = 4,
  parameter int DUP_ACK_RT        = 3,
  parameter int ACK_NUM_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TIMESTAMP_W-1:0] now_i,
  input  logic                   arm_i,
  input  logic                   ack_i,
  input  logic [ACK_NUM_W-1:0]   ack_num_i,
  input  logic                   ack_all_acked_i,
  input  logic                   scan_i,
  input  logic                   clr_to_i,
  input  logic                   clr_fast_i,
  output logic                   to_pend_o,
  output logic                   fast_pend_o
);
  localparam int CW = (TIMESTAMP_W > 32) ? TIMESTAMP_W : 32;
  localparam logic [DUP_ACK_CNT_W-1:0] DUP_MAX = '1;
  localparam logic [DUP_ACK_CNT_W-1:0] DUP_TH  = DUP_ACK_CNT_W'(DUP_ACK_RT);

  logic                     armed_q, armed_d;
  logic [TIMESTAMP_W-1:0]   start_q, start_d;
  logic [ACK_NUM_W-1:0]     last_ack_q, last_ack_d;
  logic [DUP_ACK_CNT_W-1:0] dup_q, dup_d;
  logic                     to_q, to_d, fast_q, fast_d;
  logic [TIMESTAMP_W-1:0]   age;
  logic                     ack_dup, ack_new, expire;

  always_comb begin
    age        = now_i - start_q;
    ack_dup    = ack_i && (ack_num_i == last_ack_q);
    ack_new    = ack_i && !ack_dup;
    // A fresh arm or new ACK this cycle supersedes an expiry seen by the scanner.
    expire     = scan_i && armed_q && (CW'(age) >= CW'(RT_TIMEOUT_CYCLES)) && !arm_i && !ack_new;
    armed_d    = armed_q;
    start_d    = start_q;
    last_ack_d = last_ack_q;
    dup_d      = dup_q;
    to_d       = to_q;
    fast_d     = fast_q;
    if (clr_to_i) begin
      to_d   = 1'b0;
      fast_d = 1'b0;
      dup_d  = '0;
    end
    if (clr_fast_i) fast_d = 1'b0;
    if (expire) begin
      armed_d = 1'b0;
      to_d    = 1'b1;
    end
    if (ack_dup && (dup_d != DUP_MAX)) begin
      dup_d = dup_d + 1'b1;
      if (dup_d == DUP_TH) fast_d = 1'b1;
    end
    if (ack_new) begin
      last_ack_d = ack_num_i;
      dup_d      = '0;
      fast_d     = 1'b0;
      if (ack_all_acked_i) armed_d = 1'b0;
      else                 start_d = now_i;
    end
    if (arm_i && (!armed_q || ack_new)) begin
      armed_d = 1'b1;
      start_d = now_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      start_q    <= '0;
      last_ack_q <= '0;
      dup_q      <= '0;
      to_q       <= 1'b0;
      fast_q     <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      start_q    <= start_d;
      last_ack_q <= last_ack_d;
      dup_q      <= dup_d;
      to_q       <= to_d;
      fast_q     <= fast_d;
    end
  end

  assign to_pend_o   = to_q;
  assign fast_pend_o = fast_q;
endmodule

module tcp_rt_timer_table #(
  parameter int NUM_FLOWS         = 8,
  parameter int FLOWID_W          = $clog2(NUM_FLOWS),
  parameter int TIMESTAMP_W       = 64,
  parameter int RT_TIMEOUT_CYCLES = 250000000,
  parameter int DUP_ACK_CNT_W     = 4,
  parameter int DUP_ACK_RT        = 3,
  parameter int ACK_NUM_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm_val,
  input  logic [FLOWID_W-1:0]  arm_flowid,
  input  logic                 ack_val,
  input  logic [FLOWID_W-1:0]  ack_flowid,
  input  logic [ACK_NUM_W-1:0] ack_num,
  input  logic                 ack_all_acked,
  output logic                 ack_rdy,
  output logic                 rt_req_val,
  output logic [FLOWID_W-1:0]  rt_req_flowid,
  output logic                 rt_req_fast,
  input  logic                 rt_req_rdy
);
  logic [TIMESTAMP_W-1:0] now_q;
  logic [FLOWID_W-1:0]    scan_q, rr_q, rr_d, fid_q, fid_d;
  logic                   val_q, val_d, fast_q, fast_d;
  logic [NUM_FLOWS-1:0]   arm_hit, ack_hit, scan_hit, clr_to, clr_fast;
  logic [NUM_FLOWS-1:0]   to_pend, fast_pend, pend_vis;
  logic                   hs, found, sel_fast;
  logic [FLOWID_W-1:0]    base, idx, sel;

  assign hs      = val_q && rt_req_rdy;
  assign ack_rdy = 1'b1;

  for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_flow
    assign arm_hit[g]  = arm_val && (arm_flowid == FLOWID_W'(g));
    assign ack_hit[g]  = ack_val && (ack_flowid == FLOWID_W'(g));
    assign scan_hit[g] = (scan_q == FLOWID_W'(g));
    assign clr_to[g]   = hs && (fid_q == FLOWID_W'(g)) && !fast_q;
    assign clr_fast[g] = hs && (fid_q == FLOWID_W'(g)) && fast_q;
    // Pending state as it will stand after this edge's grant clear.
    assign pend_vis[g] = (to_pend[g] && !clr_to[g]) ||
                         (fast_pend[g] && !clr_to[g] && !clr_fast[g]);
  end

  tcp_rt_flow_entry #(
    .TIMESTAMP_W      (TIMESTAMP_W),
    .RT_TIMEOUT_CYCLES(RT_TIMEOUT_CYCLES),
    .DUP_ACK_CNT_W    (DUP_ACK_CNT_W),
    .DUP_ACK_RT       (DUP_ACK_RT),
    .ACK_NUM_W        (ACK_NUM_W)
  ) u_flow [NUM_FLOWS-1:0] (
    .clk            (clk),
    .rst            (rst),
    .now_i          (now_q),
    .arm_i          (arm_hit),
    .ack_i          (ack_hit),
    .ack_num_i      (ack_num),
    .ack_all_acked_i(ack_all_acked),
    .scan_i         (scan_hit),
    .clr_to_i       (clr_to),
    .clr_fast_i     (clr_fast),
    .to_pend_o      (to_pend),
    .fast_pend_o    (fast_pend)
  );

  always_comb begin
    base  = hs ? fid_q : rr_q;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_FLOWS; i++) begin
      idx = base + FLOWID_W'(i);
      if (!found && pend_vis[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_fast = !(to_pend[sel] && !clr_to[sel]);
    val_d = val_q;
    fid_d = fid_q;
    fast_d = fast_q;
    rr_d  = rr_q;
    if (hs) rr_d = fid_q;
    if (!val_q || hs) begin
      val_d = found;
      if (found) begin
        fid_d  = sel;
        fast_d = sel_fast;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now_q  <= '0;
      scan_q <= '0;
      rr_q   <= '0;
      val_q  <= 1'b0;
      fid_q  <= '0;
      fast_q <= 1'b0;
    end else begin
      now_q  <= now_q + 1'b1;
      scan_q <= scan_q + 1'b1;
      rr_q   <= rr_d;
      val_q  <= val_d;
      fid_q  <= fid_d;
      fast_q <= fast_d;
    end
  end

  assign rt_req_val    = val_q;
  assign rt_req_flowid = fid_q;
  assign rt_req_fast   = fast_q;
endmodule

// File: tb/tb_tcp_rt_timer_table.sv
// Bench for tcp_rt_timer_table: directed scenarios plus random traffic against a reference model.
module tb_tcp_rt_timer_table;
  localparam int N = 8, TW = 8, TO = 20, DW = 4, DRT = 3, AW = 32, FW = 3;
  localparam int TMOD = 1 << TW;
  localparam int DMAX = (1 << DW) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic arm_val = 1'b0;  logic [FW-1:0] arm_flowid = '0;
  logic ack_val = 1'b0;  logic [FW-1:0] ack_flowid = '0;
  logic [AW-1:0] ack_num = '0;
  logic ack_all_acked = 1'b0, ack_rdy;
  logic rt_req_val, rt_req_fast, rt_req_rdy = 1'b0;
  logic [FW-1:0] rt_req_flowid;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  tcp_rt_timer_table #(.NUM_FLOWS(N), .TIMESTAMP_W(TW), .RT_TIMEOUT_CYCLES(TO),
    .DUP_ACK_CNT_W(DW), .DUP_ACK_RT(DRT), .ACK_NUM_W(AW)) dut (
    .clk(clk), .rst(rst), .arm_val(arm_val), .arm_flowid(arm_flowid),
    .ack_val(ack_val), .ack_flowid(ack_flowid), .ack_num(ack_num),
    .ack_all_acked(ack_all_acked), .ack_rdy(ack_rdy),
    .rt_req_val(rt_req_val), .rt_req_flowid(rt_req_flowid),
    .rt_req_fast(rt_req_fast), .rt_req_rdy(rt_req_rdy));

  // Reference model: per-flow timer records advanced once per clock edge.
  bit m_armed [N]; int m_start [N]; logic [AW-1:0] m_last [N]; int m_dup [N];
  bit m_to [N]; bit m_fp [N];
  int m_now, m_rr, m_fid; bit m_val, m_fast;

  function automatic void model_reset();
    for (int f = 0; f < N; f++) begin
      m_armed[f] = 0; m_start[f] = 0; m_last[f] = '0; m_dup[f] = 0; m_to[f] = 0; m_fp[f] = 0;
    end
    m_now = 0; m_rr = 0; m_fid = 0; m_val = 0; m_fast = 0;
  endfunction

  function automatic void model_step();
    bit hs, found, nfast, a_new, a_dup, expd, pre_armed;
    int start, nf, sf, f;
    hs = m_val && rt_req_rdy;
    if (hs) begin
      m_fp[m_fid] = 0;
      if (!m_fast) begin m_to[m_fid] = 0; m_dup[m_fid] = 0; end
    end
    if (!m_val || hs) begin
      start = hs ? m_fid : m_rr; found = 0; nf = 0; nfast = 0;
      for (int k = 1; k <= N; k++) begin
        f = (start + k) % N;
        if (!found && (m_to[f] || m_fp[f])) begin found = 1; nf = f; nfast = !m_to[f]; end
      end
      if (hs) m_rr = m_fid;
      m_val = found;
      if (found) begin m_fid = nf; m_fast = nfast; end
    end
    a_new = ack_val && (ack_num != m_last[ack_flowid]);
    a_dup = ack_val && !a_new;
    pre_armed = m_armed[arm_flowid];
    sf = m_now % N;
    expd = m_armed[sf] && (((m_now - m_start[sf] + TMOD) % TMOD) >= TO)
           && !(arm_val && arm_flowid == sf) && !(a_new && ack_flowid == sf);
    if (expd) begin m_to[sf] = 1; m_armed[sf] = 0; end
    if (a_dup && m_dup[ack_flowid] < DMAX) begin
      m_dup[ack_flowid]++;
      if (m_dup[ack_flowid] == DRT) m_fp[ack_flowid] = 1;
    end
    if (a_new) begin
      m_last[ack_flowid] = ack_num; m_dup[ack_flowid] = 0; m_fp[ack_flowid] = 0;
      if (ack_all_acked) m_armed[ack_flowid] = 0;
      else m_start[ack_flowid] = m_now;
    end
    if (arm_val && (!pre_armed || (a_new && ack_flowid == arm_flowid))) begin
      m_armed[arm_flowid] = 1; m_start[arm_flowid] = m_now;
    end
    m_now = (m_now + 1) % TMOD;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  typedef struct { int fid; bit fast; int t; } grant_t;
  grant_t glog [$];
  always @(negedge clk)
    if (!rst && rt_req_val && rt_req_rdy)
      glog.push_back('{int'(rt_req_flowid), rt_req_fast, m_now});

  task automatic step(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) step(); endtask
  task automatic do_arm(input int f);
    arm_val = 1; arm_flowid = FW'(f); step(); arm_val = 0;
  endtask
  task automatic do_ack(input int f, input int unsigned num, input bit all);
    ack_val = 1; ack_flowid = FW'(f); ack_num = num; ack_all_acked = all; step();
    ack_val = 0; ack_all_acked = 0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1; rst = 1; arm_val = 0; ack_val = 0; rt_req_rdy = 0; #3; rst = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1; rst = 1; arm_val = 0; ack_val = 0; rt_req_rdy = 0; #1;
    checks += 4;
    if (rt_req_val !== 1'b0) begin errors++; $display("FAIL rst_val: got %b want 0", rt_req_val); end
    if (rt_req_flowid !== '0) begin errors++; $display("FAIL rst_fid: got %0d want 0", rt_req_flowid); end
    if (rt_req_fast !== 1'b0) begin errors++; $display("FAIL rst_fast: got %b want 0", rt_req_fast); end
    if (ack_rdy !== 1'b1) begin errors++; $display("FAIL rst_ackrdy: got %b want 1", ack_rdy); end
    #2 rst = 0;
    rt_req_rdy = 1; idle(12);
    checks++;
    if (rt_req_val !== 1'b0) begin errors++; $display("FAIL idle_val: got %b want 0", rt_req_val); end
  endtask

  task automatic test_timeout();
    int g0, n;
    do_reset(); rt_req_rdy = 1; g0 = glog.size();
    idle(5); do_arm(2); idle(70);
    n = glog.size() - g0;
    checks++;
    if (n != 1) begin errors++; $display("FAIL to_count: got %0d want 1", n); end
    if (n >= 1) begin
      checks += 2;
      if (glog[g0].fid != 2 || glog[g0].fast != 0) begin
        errors++; $display("FAIL to_grant: got fid=%0d fast=%0d want fid=2 fast=0", glog[g0].fid, glog[g0].fast);
      end
      if (glog[g0].t < 25 || glog[g0].t > 33) begin
        errors++; $display("FAIL to_window: got t=%0d want 25..33", glog[g0].t);
      end
    end
  endtask

  task automatic test_fast_retx();
    int g0, n, t3;
    do_reset(); rt_req_rdy = 1; g0 = glog.size();
    do_ack(4, 100, 0); do_ack(4, 100, 0); do_ack(4, 100, 0);
    t3 = m_now; do_ack(4, 100, 0);
    idle(10); do_ack(4, 100, 0); idle(30);
    n = glog.size() - g0;
    checks++;
    if (n != 1) begin errors++; $display("FAIL fast_count: got %0d want 1", n); end
    if (n >= 1) begin
      checks += 2;
      if (glog[g0].fid != 4 || glog[g0].fast != 1) begin
        errors++; $display("FAIL fast_grant: got fid=%0d fast=%0d want fid=4 fast=1", glog[g0].fid, glog[g0].fast);
      end
      if (glog[g0].t <= t3) begin errors++; $display("FAIL fast_order: got t=%0d want >%0d", glog[g0].t, t3); end
    end
  endtask

  task automatic test_ack_clears();
    int g0, n;
    do_reset(); rt_req_rdy = 1; g0 = glog.size();
    do_arm(1); idle(9); do_ack(1, 55, 1); idle(60);
    n = glog.size() - g0;
    checks++;
    if (n != 0) begin errors++; $display("FAIL allacked_count: got %0d want 0", n); end
    do_arm(1);
    for (int k = 0; k < 8; k++) begin idle(14); do_ack(1, 1000 + k, 0); end
    idle(5);
    n = glog.size() - g0;
    checks++;
    if (n != 0) begin errors++; $display("FAIL restart_count: got %0d want 0", n); end
  endtask

  task automatic test_backpressure();
    int g0, n;
    do_reset(); rt_req_rdy = 0; g0 = glog.size();
    idle(4); do_arm(0); do_arm(3); do_arm(6);
    while (m_now < 26) step();
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (rt_req_val !== 1'b1 || rt_req_flowid !== 3'd0 || rt_req_fast !== 1'b0) begin
        errors++; $display("FAIL bp_hold: got val=%b fid=%0d fast=%b want 1/0/0", rt_req_val, rt_req_flowid, rt_req_fast);
      end
      step();
    end
    rt_req_rdy = 1; idle(10);
    n = glog.size() - g0;
    checks++;
    if (n != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", n); end
    else begin
      checks++;
      if (glog[g0].fid != 0 || glog[g0+1].fid != 3 || glog[g0+2].fid != 6 ||
          glog[g0].fast || glog[g0+1].fast || glog[g0+2].fast ||
          glog[g0+1].t != glog[g0].t + 1 || glog[g0+2].t != glog[g0+1].t + 1) begin
        errors++;
        $display("FAIL bp_order: got %0d@%0d %0d@%0d %0d@%0d want 0,3,6 consecutive fast=0",
                 glog[g0].fid, glog[g0].t, glog[g0+1].fid, glog[g0+1].t, glog[g0+2].fid, glog[g0+2].t);
      end
    end
  endtask

  task automatic test_to_over_fast();
    int g0, n;
    do_reset(); rt_req_rdy = 0; g0 = glog.size();
    step(); do_arm(0); do_arm(5);
    while (m_now < 31) step();
    do_ack(5, 0, 0); do_ack(5, 0, 0); do_ack(5, 0, 0);
    idle(2); rt_req_rdy = 1; idle(40);
    n = glog.size() - g0;
    checks++;
    if (n != 2) begin errors++; $display("FAIL both_count: got %0d want 2", n); end
    else begin
      checks++;
      if (glog[g0].fid != 0 || glog[g0].fast || glog[g0+1].fid != 5 || glog[g0+1].fast) begin
        errors++; $display("FAIL both_grant: got %0d/%0d %0d/%0d want 0/0 5/0",
                           glog[g0].fid, glog[g0].fast, glog[g0+1].fid, glog[g0+1].fast);
      end
    end
    do_ack(5, 0, 0); do_ack(5, 0, 0); do_ack(5, 0, 0); idle(10);
    n = glog.size() - g0;
    checks++;
    if (n != 3 || glog[glog.size()-1].fid != 5 || !glog[glog.size()-1].fast) begin
      errors++; $display("FAIL dupclr_grant: got count=%0d want 3 ending fid=5 fast=1", n);
    end
  endtask

  task automatic test_reset_mid_req();
    int g0, w;
    do_reset(); rt_req_rdy = 0;
    do_arm(3);
    w = 0;
    while (rt_req_val !== 1'b1 && w < 60) begin step(); w++; end
    checks++;
    if (rt_req_val !== 1'b1) begin errors++; $display("FAIL midrst_setup: got val=%b want 1 within 60 cycles", rt_req_val); end
    #2 rst = 1; #1;
    checks++;
    if (rt_req_val !== 1'b0 || rt_req_flowid !== '0 || rt_req_fast !== 1'b0) begin
      errors++; $display("FAIL midrst_out: got val=%b fid=%0d fast=%b want 0/0/0", rt_req_val, rt_req_flowid, rt_req_fast);
    end
    rst = 0; g0 = glog.size(); rt_req_rdy = 1; idle(60);
    checks++;
    if (glog.size() != g0) begin errors++; $display("FAIL midrst_stale: got %0d grants want 0", glog.size() - g0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      arm_val = ($urandom_range(0, 3) == 0); arm_flowid = FW'($urandom_range(0, N-1));
      ack_val = ($urandom_range(0, 2) == 0); ack_flowid = FW'($urandom_range(0, N-1));
      ack_num = AW'($urandom_range(0, 3)); ack_all_acked = ($urandom_range(0, 3) == 0);
      rt_req_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (rt_req_val !== m_val || ack_rdy !== 1'b1) begin
        errors++; $display("FAIL rnd_val: cyc %0d got val=%b ackrdy=%b want val=%b ackrdy=1", i, rt_req_val, ack_rdy, m_val);
      end
      if (m_val) begin
        checks++;
        if (rt_req_flowid !== FW'(m_fid) || rt_req_fast !== m_fast) begin
          errors++; $display("FAIL rnd_req: cyc %0d got fid=%0d fast=%b want fid=%0d fast=%b",
                             i, rt_req_flowid, rt_req_fast, m_fid, m_fast);
        end
      end
      step();
    end
    arm_val = 0; ack_val = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timeout();
    test_fast_retx();
    test_ack_clears();
    test_backpressure();
    test_to_over_fast();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
